// File: rtl/usb_txn_sequencer.sv
// Device-side USB transaction sequencer: token check, data/handshake phases, per-endpoint toggles.
// Optional endpoint halt/STALL support is enabled by defining USB_STALL_EN.
module usb_txn_sequencer #(
    parameter int NUM_EP      = 4,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        dev_addr,
    input  logic [23:0]       token,
    input  logic              token_valid,
    input  logic [7:0]        rx_pid,
    input  logic              rx_valid,
    input  logic              rx_crc_ok,
    input  logic              ep_rx_ready,
    input  logic              ep_tx_ready,
    input  logic              tx_done,
`ifdef USB_STALL_EN
    input  logic [NUM_EP-1:0] ep_halt,
`endif
    output logic [7:0]        tx_pid,
    output logic              tx_valid,
    output logic              tx_data,
    output logic [3:0]        ep_sel,
    output logic              ep_write,
    output logic              ep_read_ack,
    output logic              setup_rx,
    output logic              busy,
    output logic              err_crc
);
    localparam int EPW   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYC);

    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
`ifdef USB_STALL_EN
    localparam logic [7:0] PID_STALL = 8'h1E;
`endif

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_TOK_CHK   = 3'd1;
    localparam logic [2:0] S_WAIT_DATA = 3'd2;
    localparam logic [2:0] S_SEND_HS   = 3'd3;
    localparam logic [2:0] S_SEND_DATA = 3'd4;
    localparam logic [2:0] S_WAIT_HS   = 3'd5;

    logic [2:0]       state;
    logic [23:0]      tok_reg;
    logic             is_setup;
    logic [CNT_W-1:0] cnt;
    logic [NUM_EP-1:0] rx_tog;
    logic [NUM_EP-1:0] tx_tog;

    logic [7:0]     tok_pid;
    logic [3:0]     tok_endp;
    logic [EPW-1:0] tidx;
    logic [EPW-1:0] cidx;
    logic           crc_bad;
    logic           tok_match;
    logic           timed_out;
    logic           halt_tok;
    logic           halt_cur;

    // Serial MSB-first LFSR, x^5+x^2+1, zero init: matches CRC5_D11 with crc=0.
    function automatic logic [4:0] crc5_d11(input logic [10:0] d);
        logic [4:0] c;
        c = 5'b0;
        for (int i = 10; i >= 0; i--) begin
            if (d[i] ^ c[4])
                c = {c[3:0], 1'b0} ^ 5'b00101;
            else
                c = {c[3:0], 1'b0};
        end
        return c;
    endfunction

    assign tok_pid   = tok_reg[23:16];
    assign tok_endp  = tok_reg[8:5];
    assign tidx      = tok_reg[5 +: EPW];
    assign cidx      = ep_sel[EPW-1:0];
    assign crc_bad   = crc5_d11(tok_reg[15:5]) != tok_reg[4:0];
    assign tok_match = (tok_pid[7:4] == ~tok_pid[3:0]) && (tok_reg[15:9] == dev_addr)
                       && ({1'b0, tok_endp} < 5'(NUM_EP));
    assign timed_out = (cnt == CNT_W'(TIMEOUT_CYC - 1));

`ifdef USB_STALL_EN
    assign halt_tok = ep_halt[tidx];
    assign halt_cur = ep_halt[cidx];
`else
    assign halt_tok = 1'b0;
    assign halt_cur = 1'b0;
`endif

    assign tx_valid = (state == S_SEND_HS) || (state == S_SEND_DATA);
    assign tx_data  = (state == S_SEND_DATA);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            tok_reg     <= '0;
            is_setup    <= 1'b0;
            cnt         <= '0;
            rx_tog      <= '0;
            tx_tog      <= '0;
            tx_pid      <= '0;
            ep_sel      <= '0;
            ep_write    <= 1'b0;
            ep_read_ack <= 1'b0;
            setup_rx    <= 1'b0;
            err_crc     <= 1'b0;
        end else begin
            ep_write    <= 1'b0;
            ep_read_ack <= 1'b0;
            setup_rx    <= 1'b0;
            err_crc     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (token_valid) begin
                        tok_reg <= token;
                        state   <= S_TOK_CHK;
                    end
                end
                S_TOK_CHK: begin
                    if (crc_bad) begin
                        err_crc <= 1'b1;
                        state   <= S_IDLE;
                    end else if (!tok_match) begin
                        state <= S_IDLE;
                    end else begin
                        case (tok_pid)
                            PID_SETUP: begin
                                ep_sel       <= tok_endp;
                                is_setup     <= 1'b1;
                                rx_tog[tidx] <= 1'b0;
                                tx_tog[tidx] <= 1'b1;
                                cnt          <= '0;
                                state        <= S_WAIT_DATA;
                            end
                            PID_OUT: begin
                                ep_sel   <= tok_endp;
                                is_setup <= 1'b0;
                                cnt      <= '0;
                                state    <= S_WAIT_DATA;
                            end
                            PID_IN: begin
                                ep_sel <= tok_endp;
                                if (halt_tok) begin
`ifdef USB_STALL_EN
                                    tx_pid <= PID_STALL;
`endif
                                    state  <= S_SEND_HS;
                                end else if (ep_tx_ready) begin
                                    tx_pid <= tx_tog[tidx] ? PID_DATA1 : PID_DATA0;
                                    state  <= S_SEND_DATA;
                                end else begin
                                    tx_pid <= PID_NAK;
                                    state  <= S_SEND_HS;
                                end
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                // A data packet that arrives on the expiry cycle is still honoured.
                S_WAIT_DATA: begin
                    if (rx_valid) begin
                        if (rx_pid != PID_DATA0 && rx_pid != PID_DATA1) begin
                            state <= S_IDLE;
                        end else if (!rx_crc_ok) begin
                            err_crc <= 1'b1;
                            state   <= S_IDLE;
                        end else if (!is_setup && halt_cur) begin
`ifdef USB_STALL_EN
                            tx_pid <= PID_STALL;
`endif
                            state  <= S_SEND_HS;
                        end else if (!is_setup && !ep_rx_ready) begin
                            tx_pid <= PID_NAK;
                            state  <= S_SEND_HS;
                        end else if ((rx_pid == PID_DATA1) != rx_tog[cidx]) begin
                            tx_pid <= PID_ACK;
                            state  <= S_SEND_HS;
                        end else begin
                            ep_write     <= 1'b1;
                            setup_rx     <= is_setup;
                            rx_tog[cidx] <= ~rx_tog[cidx];
                            tx_pid       <= PID_ACK;
                            state        <= S_SEND_HS;
                        end
                    end else if (timed_out) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SEND_HS: begin
                    if (tx_done)
                        state <= S_IDLE;
                end
                S_SEND_DATA: begin
                    if (tx_done) begin
                        cnt   <= '0;
                        state <= S_WAIT_HS;
                    end
                end
                S_WAIT_HS: begin
                    if (rx_valid) begin
                        if (rx_pid == PID_ACK) begin
                            ep_read_ack  <= 1'b1;
                            tx_tog[cidx] <= ~tx_tog[cidx];
                        end
                        state <= S_IDLE;
                    end else if (timed_out) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_txn_sequencer.sv
// Scoreboard bench for usb_txn_sequencer: directed transactions queue expected events,
// a negedge monitor pops and compares each DUT event. Covers USB_STALL_EN when defined.
module tb_usb_txn_sequencer;
    localparam logic [7:0] PID_OUT   = 8'hE1;
    localparam logic [7:0] PID_IN    = 8'h69;
    localparam logic [7:0] PID_SETUP = 8'h2D;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;
    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NAK   = 8'h5A;
    localparam logic [7:0] PID_STALL = 8'h1E;

    localparam logic [1:0] EV_WRITE = 2'd0;
    localparam logic [1:0] EV_ERR   = 2'd1;
    localparam logic [1:0] EV_RDACK = 2'd2;
    localparam logic [1:0] EV_TX    = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] pid;
        logic       flag;
        logic [3:0] ep;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  dev_addr = 7'h7F;
    logic [23:0] token = '0;
    logic        token_valid = 1'b0;
    logic [7:0]  rx_pid = '0;
    logic        rx_valid = 1'b0;
    logic        rx_crc_ok = 1'b0;
    logic        ep_rx_ready = 1'b1;
    logic        ep_tx_ready = 1'b1;
    logic        tx_done = 1'b0;
`ifdef USB_STALL_EN
    logic [3:0]  ep_halt = '0;
`endif
    logic [7:0]  tx_pid;
    logic        tx_valid;
    logic        tx_data;
    logic [3:0]  ep_sel;
    logic        ep_write;
    logic        ep_read_ack;
    logic        setup_rx;
    logic        busy;
    logic        err_crc;

    int  compared = 0;
    int  mismatched = 0;
    ev_t expq[$];
    logic prev_txv = 1'b0;

    usb_txn_sequencer #(.NUM_EP(4), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .dev_addr(dev_addr), .token(token), .token_valid(token_valid),
        .rx_pid(rx_pid), .rx_valid(rx_valid), .rx_crc_ok(rx_crc_ok),
        .ep_rx_ready(ep_rx_ready), .ep_tx_ready(ep_tx_ready), .tx_done(tx_done),
`ifdef USB_STALL_EN
        .ep_halt(ep_halt),
`endif
        .tx_pid(tx_pid), .tx_valid(tx_valid), .tx_data(tx_data), .ep_sel(ep_sel),
        .ep_write(ep_write), .ep_read_ack(ep_read_ack), .setup_rx(setup_rx),
        .busy(busy), .err_crc(err_crc)
    );

    always #5 clk = ~clk;

    // Reference CRC5_D11 with zero seed, written as parallel XOR equations.
    function automatic logic [4:0] crc5Model(input logic [10:0] d);
        logic [4:0] c;
        c[0] = d[10]^d[9]^d[6]^d[5]^d[3]^d[0];
        c[1] = d[10]^d[7]^d[6]^d[4]^d[1];
        c[2] = d[10]^d[9]^d[8]^d[7]^d[6]^d[3]^d[2]^d[0];
        c[3] = d[10]^d[9]^d[8]^d[7]^d[4]^d[3]^d[1];
        c[4] = d[10]^d[9]^d[8]^d[5]^d[4]^d[2];
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic expectEv(input logic [1:0] kind, input logic [7:0] pid, input logic flag,
                            input logic [3:0] ep);
        ev_t e;
        e.kind = kind; e.pid = pid; e.flag = flag; e.ep = ep;
        expq.push_back(e);
    endtask

    function automatic bit evMatch(input ev_t e, input ev_t a);
        if (e.kind != a.kind) return 1'b0;
        case (e.kind)
            EV_TX:    return (e.pid == a.pid) && (e.flag == a.flag) && (e.ep == a.ep);
            EV_WRITE: return (e.flag == a.flag) && (e.ep == a.ep);
            EV_RDACK: return (e.ep == a.ep);
            default:  return 1'b1;
        endcase
    endfunction

    task automatic checkEvent(input ev_t a);
        ev_t e;
        compared++;
        if (expq.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_event actual kind=%0d pid=%h flag=%0d ep=%0d required none",
                     a.kind, a.pid, a.flag, a.ep);
        end else begin
            e = expq.pop_front();
            if (!evMatch(e, a)) begin
                mismatched++;
                $display("[TB] FAIL event actual kind=%0d pid=%h flag=%0d ep=%0d required kind=%0d pid=%h flag=%0d ep=%0d",
                         a.kind, a.pid, a.flag, a.ep, e.kind, e.pid, e.flag, e.ep);
            end
        end
    endtask

    // Monitor: same-cycle events are checked in a fixed order WRITE, ERR, RDACK, TX.
    always @(negedge clk) begin
        if (ep_write)              checkEvent({EV_WRITE, 8'h00, setup_rx, ep_sel});
        if (err_crc)               checkEvent({EV_ERR, 8'h00, 1'b0, 4'h0});
        if (ep_read_ack)           checkEvent({EV_RDACK, 8'h00, 1'b0, ep_sel});
        if (tx_valid && !prev_txv) checkEvent({EV_TX, tx_pid, tx_data, ep_sel});
        prev_txv = tx_valid;
    end

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] pid, input logic [6:0] addr,
                                 input logic [3:0] endp, input logic corrupt);
        logic [10:0] d;
        d = {addr, endp};
        token = {pid, d, crc5Model(d) ^ {4'b0, corrupt}};
        token_valid = 1'b1;
        @(negedge clk);
        token_valid = 1'b0;
    endtask

    task automatic sendRx(input logic [7:0] pid, input logic crc_ok);
        rx_pid = pid; rx_crc_ok = crc_ok; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic waitTx(input bit complete);
        int n;
        n = 0;
        while (!tx_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!tx_valid) begin
            compared++; mismatched++;
            $display("[TB] FAIL tx_valid_timeout actual=0 required=1");
        end else if (complete) begin
            tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            compared++; mismatched++;
            $display("[TB] FAIL idle_timeout actual busy=1 required busy=0");
        end
    endtask

    // OUT/SETUP transaction: token, data packet, optional handshake.
    task automatic doRxTxn(input logic [7:0] tok, input logic [3:0] ep,
                           input logic [7:0] dpid, input logic crc_ok, input bit has_hs);
        applyStimulus(tok, 7'h7F, ep, 1'b0);
        waitCycles(1);
        sendRx(dpid, crc_ok);
        if (has_hs) waitTx(1'b1);
        waitIdle();
        waitCycles(1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        waitCycles(3);
        checkOutput("reset_outputs",
                    {12'b0, tx_pid, tx_valid, tx_data, ep_sel, ep_write, ep_read_ack, setup_rx, busy, err_crc},
                    32'h0);
        rst = 1'b0;
        waitCycles(2);

        // SETUP then OUT DATA1 on endpoint 0 (SETUP leaves rx toggle at 1).
        expectEv(EV_WRITE, 8'h00, 1'b1, 4'd0);
        expectEv(EV_TX, PID_ACK, 1'b0, 4'd0);
        doRxTxn(PID_SETUP, 4'd0, PID_DATA0, 1'b1, 1'b1);
        expectEv(EV_WRITE, 8'h00, 1'b0, 4'd0);
        expectEv(EV_TX, PID_ACK, 1'b0, 4'd0);
        doRxTxn(PID_OUT, 4'd0, PID_DATA1, 1'b1, 1'b1);

        // OUT endpoint 1: fresh DATA0 then a duplicate DATA0.
        expectEv(EV_WRITE, 8'h00, 1'b0, 4'd1);
        expectEv(EV_TX, PID_ACK, 1'b0, 4'd1);
        doRxTxn(PID_OUT, 4'd1, PID_DATA0, 1'b1, 1'b1);
        expectEv(EV_TX, PID_ACK, 1'b0, 4'd1);
        doRxTxn(PID_OUT, 4'd1, PID_DATA0, 1'b1, 1'b1);

        // IN endpoint 2: DATA0 acked, then DATA1 with host silence.
        expectEv(EV_TX, PID_DATA0, 1'b1, 4'd2);
        expectEv(EV_RDACK, 8'h00, 1'b0, 4'd2);
        applyStimulus(PID_IN, 7'h7F, 4'd2, 1'b0);
        waitTx(1'b1);
        sendRx(PID_ACK, 1'b1);
        waitIdle();
        expectEv(EV_TX, PID_DATA1, 1'b1, 4'd2);
        applyStimulus(PID_IN, 7'h7F, 4'd2, 1'b0);
        waitTx(1'b1);
        waitCycles(15);
        checkOutput("busy_before_timeout", {31'b0, busy}, 32'd1);
        waitCycles(1);
        checkOutput("busy_after_timeout", {31'b0, busy}, 32'd0);
        // Still DATA1; host ACK lands exactly on the expiry cycle and must win.
        expectEv(EV_TX, PID_DATA1, 1'b1, 4'd2);
        expectEv(EV_RDACK, 8'h00, 1'b0, 4'd2);
        applyStimulus(PID_IN, 7'h7F, 4'd2, 1'b0);
        waitTx(1'b1);
        waitCycles(15);
        sendRx(PID_ACK, 1'b1);
        waitIdle();
        expectEv(EV_TX, PID_DATA0, 1'b1, 4'd2);
        expectEv(EV_RDACK, 8'h00, 1'b0, 4'd2);
        applyStimulus(PID_IN, 7'h7F, 4'd2, 1'b0);
        waitTx(1'b1);
        sendRx(PID_ACK, 1'b1);
        waitIdle();

        // IN with no data gives NAK; foreign address and out-of-range endpoint are dropped.
        ep_tx_ready = 1'b0;
        expectEv(EV_TX, PID_NAK, 1'b0, 4'd3);
        applyStimulus(PID_IN, 7'h7F, 4'd3, 1'b0);
        waitTx(1'b1);
        waitIdle();
        ep_tx_ready = 1'b1;
        applyStimulus(PID_IN, 7'h12, 4'd2, 1'b0);
        checkOutput("busy_in_tok_chk", {31'b0, busy}, 32'd1);
        waitCycles(1);
        checkOutput("busy_after_bad_addr", {31'b0, busy}, 32'd0);
        applyStimulus(PID_OUT, 7'h7F, 4'd5, 1'b0);
        waitCycles(1);
        checkOutput("busy_after_bad_endp", {31'b0, busy}, 32'd0);

        // CRC failures: corrupted token, then corrupted data (toggle must not flip).
        expectEv(EV_ERR, 8'h00, 1'b0, 4'd0);
        applyStimulus(PID_SETUP, 7'h7F, 4'd0, 1'b1);
        waitCycles(2);
        expectEv(EV_ERR, 8'h00, 1'b0, 4'd0);
        doRxTxn(PID_OUT, 4'd1, PID_DATA1, 1'b0, 1'b0);
        expectEv(EV_WRITE, 8'h00, 1'b0, 4'd1);
        expectEv(EV_TX, PID_ACK, 1'b0, 4'd1);
        doRxTxn(PID_OUT, 4'd1, PID_DATA1, 1'b1, 1'b1);
        ep_rx_ready = 1'b0;
        expectEv(EV_TX, PID_NAK, 1'b0, 4'd1);
        doRxTxn(PID_OUT, 4'd1, PID_DATA0, 1'b1, 1'b1);
        ep_rx_ready = 1'b1;

`ifdef USB_STALL_EN
        ep_halt = 4'b0010;
        expectEv(EV_TX, PID_STALL, 1'b0, 4'd1);
        doRxTxn(PID_OUT, 4'd1, PID_DATA0, 1'b1, 1'b1);
        expectEv(EV_TX, PID_STALL, 1'b0, 4'd1);
        applyStimulus(PID_IN, 7'h7F, 4'd1, 1'b0);
        waitTx(1'b1);
        waitIdle();
        ep_halt = 4'b0000;
`endif

        // Set rx toggle[3], then reset during SEND_DATA (ep2 tx toggle is 1).
        expectEv(EV_WRITE, 8'h00, 1'b0, 4'd3);
        expectEv(EV_TX, PID_ACK, 1'b0, 4'd3);
        doRxTxn(PID_OUT, 4'd3, PID_DATA0, 1'b1, 1'b1);
        expectEv(EV_TX, PID_DATA1, 1'b1, 4'd2);
        applyStimulus(PID_IN, 7'h7F, 4'd2, 1'b0);
        waitTx(1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_txn_reset_outputs",
                    {12'b0, tx_pid, tx_valid, tx_data, ep_sel, ep_write, ep_read_ack, setup_rx, busy, err_crc},
                    32'h0);
        rst = 1'b0;
        waitCycles(1);
        expectEv(EV_TX, PID_DATA0, 1'b1, 4'd2);
        expectEv(EV_RDACK, 8'h00, 1'b0, 4'd2);
        applyStimulus(PID_IN, 7'h7F, 4'd2, 1'b0);
        waitTx(1'b1);
        sendRx(PID_ACK, 1'b1);
        waitIdle();
        expectEv(EV_WRITE, 8'h00, 1'b0, 4'd3);
        expectEv(EV_TX, PID_ACK, 1'b0, 4'd3);
        doRxTxn(PID_OUT, 4'd3, PID_DATA0, 1'b1, 1'b1);

        waitCycles(3);
        checkOutput("scoreboard_drained", expq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/usb_txn_sequencer.md
Name: usb_txn_sequencer

Overview:
- Device-side USB transaction controller; sequences token -> data -> handshake phases for one function address.
- Sits between the packet receive path (token/data capture, CRC5_D11 checker pattern) and the TS transmit datapath.
- Validates tokens, tracks per-endpoint data toggles, and tells the transmitter which PID to send and when.

Parameters:
- NUM_EP, 4, number of endpoints (1..16); endp >= NUM_EP is ignored.
- TIMEOUT_CYC, 16, clk cycles waited for a host packet before abandoning the transaction (>= 2).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- dev_addr  input  7  assigned device address
- token  input  24  {pid[7:0], addr[6:0], endp[3:0], crc5[4:0]}
- token_valid  input  1  one-cycle strobe, token stable that cycle
- rx_pid  input  8  PID of received data/handshake packet
- rx_valid  input  1  one-cycle strobe, rx_pid stable
- rx_crc_ok  input  1  CRC16 result for data packet, qualified by rx_valid
- ep_rx_ready  input  1  selected endpoint can accept OUT/SETUP data
- ep_tx_ready  input  1  selected endpoint has IN data
- tx_done  input  1  TS finished sending the requested packet
- tx_pid  output  8  PID to transmit
- tx_valid  output  1  request to TS; held until tx_done
- tx_data  output  1  1 = DATA packet with endpoint payload, 0 = handshake only
- ep_sel  output  4  endpoint of current transaction
- ep_write  output  1  one-cycle commit of received payload
- ep_read_ack  output  1  one-cycle: IN payload acknowledged by host
- setup_rx  output  1  one-cycle: SETUP payload committed
- busy  output  1  high in every state except IDLE
- err_crc  output  1  one-cycle pulse on token CRC5 or data CRC16 failure

Behaviour:
- PIDs: OUT E1, IN 69, SETUP 2D, DATA0 C3, DATA1 4B, ACK D2, NAK 5A, STALL 1E. PID byte valid only if pid[7:4] == ~pid[3:0].
- CRC5 is computed internally over token[15:5]:
  - polynomial x^5+x^2+1, init 0, no final inversion;
  - bit-identical to CRC5_D11 with crc=0.
- Reset: state IDLE; all outputs 0; all toggles 0.
- States:
  - IDLE: on token_valid -> TOK_CHK (token registered).
  - TOK_CHK, 1 cycle:
    - CRC5 mismatch -> err_crc, IDLE.
    - Bad PID check, addr != dev_addr, or endp >= NUM_EP -> IDLE silently.
    - SETUP -> rx toggle[endp] := 0, tx toggle[endp] := 1, then WAIT_DATA.
    - OUT -> WAIT_DATA.
    - IN -> SEND_DATA if ep_tx_ready, else SEND_HS with NAK.
    - Any other PID -> IDLE.
  - WAIT_DATA: wait for rx_valid, bounded by timeout counter.
    - Timeout -> IDLE.
    - rx_pid not DATA0/DATA1 -> IDLE.
    - !rx_crc_ok -> err_crc, IDLE, no handshake.
    - OUT with !ep_rx_ready -> NAK.
    - PID toggle != rx toggle -> ACK, no ep_write, no flip (duplicate).
    - Otherwise -> ep_write (plus setup_rx if SETUP), flip rx toggle, ACK.
    - SETUP always ACKs; ep_rx_ready is ignored.
  - SEND_HS: tx_valid=1, tx_data=0, tx_pid=handshake; on tx_done -> IDLE.
  - SEND_DATA: tx_valid=1, tx_data=1, tx_pid=DATA{tx toggle}; on tx_done -> WAIT_HS.
  - WAIT_HS:
    - ACK -> ep_read_ack, flip tx toggle, IDLE.
    - Timeout or any other PID -> IDLE, no flip.
- Timeout counter: cleared on entering WAIT_DATA/WAIT_HS, increments each cycle; expires when it reaches TIMEOUT_CYC-1. rx_valid in the expiry cycle wins.
- Handshake timing: tx_valid rises the cycle after the deciding event and holds until tx_done. tx_pid is stable while tx_valid is high.
- token_valid outside IDLE is ignored. rx_valid in IDLE/TOK_CHK/SEND_* is ignored.
- rst mid-transaction: returns to IDLE next edge; toggles cleared; no strobes emitted.
- ep_sel holds the registered endp from TOK_CHK until the next accepted token.

Optional Feature:
- Macro: USB_STALL_EN.
- Defined: adds input ep_halt[NUM_EP-1:0].
  - Halted endpoint answers IN with STALL.
  - Halted endpoint answers OUT data (after CRC ok) with STALL; no ep_write, no flip.
  - SETUP is never stalled.
- Undefined: port absent; STALL never generated.

Test Plan:
1. SETUP to addr 7F, endp 0, correct CRC; DATA0 with crc ok -> ep_write=1 and setup_rx=1 same cycle; tx_pid=D2, tx_data=0; rx toggle[0]=1.
2. OUT addr 7F endp 1, ep_rx_ready=1, DATA0 then repeat with DATA0 -> first: ep_write + ACK; second: ACK with no ep_write.
3. IN endp 2, ep_tx_ready=1 -> tx_pid=C3, tx_data=1; host ACK -> ep_read_ack, next IN sends 4B. Then no ACK for TIMEOUT_CYC cycles -> busy drops, next IN still 4B.
4. IN with ep_tx_ready=0 -> tx_pid=5A. Token with addr 12 while dev_addr=7F -> busy deasserts after TOK_CHK, no tx_valid.
5. Token crc5 bit flipped -> err_crc pulse, no tx_valid. Data rx_crc_ok=0 -> err_crc, no handshake.
6. rst asserted during SEND_DATA with tx_valid high -> all outputs 0 next cycle, toggles 0. USB_STALL_EN build: ep_halt[1]=1, OUT endp 1 -> tx_pid=1E.
